// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command initiator: FSM states,
// AXI response encodings and the fixed protection attribute.
package axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_AR,
    S_RD_R
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master_cmd.sv
// AXI4-Lite initiator: converts one local command into a single AXI4-Lite
// write or read, one transaction in flight, completion returned as a pulse.
module axil_master_cmd
  import axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  axil_state_e                   r_state, w_state_nxt;
  logic                          r_cmd_ready, w_cmd_ready_nxt;
  logic                          r_awvalid, w_awvalid_nxt;
  logic                          r_wvalid, w_wvalid_nxt;
  logic                          r_arvalid, w_arvalid_nxt;
  logic                          r_bready, w_bready_nxt;
  logic                          r_rready, w_rready_nxt;
  logic                          r_rsp_valid, w_rsp_valid_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]             r_wstrb, w_wstrb_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]                    r_rsp_resp, w_rsp_resp_nxt;
  logic                          w_accept;

  assign w_accept = cmd_valid && r_cmd_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_awvalid_nxt   = 1'b0;
    w_wvalid_nxt    = 1'b0;
    w_arvalid_nxt   = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          w_wstrb_nxt = cmd_wstrb;
          if (cmd_write) begin
            w_state_nxt   = S_WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RD_AR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      // AW and W retire independently; B phase starts once both are done
      S_WR: begin
        w_awvalid_nxt = r_awvalid && !M_AXI_AWREADY;
        w_wvalid_nxt  = r_wvalid && !M_AXI_WREADY;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt = S_WR_B;
        end
      end
      S_WR_B: begin
        if (M_AXI_BVALID) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = M_AXI_BRESP;
        end
      end
      S_RD_AR: begin
        w_arvalid_nxt = !M_AXI_ARREADY;
        if (M_AXI_ARREADY) begin
          w_state_nxt = S_RD_R;
        end
      end
      S_RD_R: begin
        if (M_AXI_RVALID) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = M_AXI_RDATA;
          w_rsp_resp_nxt  = M_AXI_RRESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_bready_nxt    = (w_state_nxt == S_WR_B);
    w_rready_nxt    = (w_state_nxt == S_RD_R);
    // Held low for the completion cycle so it returns one cycle after rsp_valid
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && (r_state == S_IDLE);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: a 4-word stub slave with programmable READY/
// VALID delays and responses, a table of vectors, directed corner sequences,
// and random commands checked against a word-memory reference model.
module tb_axil_master_cmd;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  axil_master_cmd #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Stub slave configuration, changed only while the master is idle
  int         cfgAwDelay = 0, cfgWDelay = 0, cfgArDelay = 0, cfgBDelay = 0, cfgRDelay = 0;
  logic [1:0] cfgBresp = 2'b00, cfgRresp = 2'b00;

  int            awWait = 0, wWait = 0, arWait = 0, bWait = 0, rWait = 0;
  logic          awGot = 1'b0, wGot = 1'b0, bPending = 1'b0, rPending = 1'b0;
  logic [AW-1:0] sAwAddr = '0, sArAddr = '0, selAddr;
  logic [DW-1:0] sWData = '0, selData;
  logic [SW-1:0] sWStrb = '0, selStrb;
  logic [DW-1:0] slaveMem [4];
  logic          awHs, wHs, arHs;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !awGot && (awWait >= cfgAwDelay);
  assign M_AXI_WREADY  = M_AXI_WVALID && !wGot && (wWait >= cfgWDelay);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (arWait >= cfgArDelay);
  assign M_AXI_BVALID  = bPending && (bWait >= cfgBDelay);
  assign M_AXI_RVALID  = rPending && (rWait >= cfgRDelay);
  assign M_AXI_BRESP   = cfgBresp;
  assign M_AXI_RRESP   = cfgRresp;
  assign M_AXI_RDATA   = slaveMem[sArAddr[3:2]];
  assign awHs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign wHs     = M_AXI_WVALID && M_AXI_WREADY;
  assign arHs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign selAddr = awHs ? M_AXI_AWADDR : sAwAddr;
  assign selData = wHs ? M_AXI_WDATA : sWData;
  assign selStrb = wHs ? M_AXI_WSTRB : sWStrb;

  // Slave: counts VALID cycles to time READY, commits the write once both
  // AW and W have been seen, then serves B and R after their delays
  always @(posedge clk) begin
    if (reset) begin
      awWait <= 0; wWait <= 0; arWait <= 0; bWait <= 0; rWait <= 0;
      awGot <= 1'b0; wGot <= 1'b0; bPending <= 1'b0; rPending <= 1'b0;
      for (int k = 0; k < 4; k++) slaveMem[k] <= '0;
    end else begin
      if (awHs) awWait <= 0; else if (M_AXI_AWVALID) awWait <= awWait + 1;
      if (wHs) wWait <= 0; else if (M_AXI_WVALID) wWait <= wWait + 1;
      if (arHs) arWait <= 0; else if (M_AXI_ARVALID) arWait <= arWait + 1;
      if (awHs) sAwAddr <= M_AXI_AWADDR;
      if (wHs) begin
        sWData <= M_AXI_WDATA;
        sWStrb <= M_AXI_WSTRB;
      end
      if ((awGot || awHs) && (wGot || wHs) && !bPending) begin
        for (int b = 0; b < SW; b++)
          if (selStrb[b]) slaveMem[selAddr[3:2]][8*b +: 8] <= selData[8*b +: 8];
        bPending <= 1'b1;
        awGot <= 1'b0;
        wGot <= 1'b0;
      end else begin
        if (awHs) awGot <= 1'b1;
        if (wHs) wGot <= 1'b1;
      end
      if (!bPending) bWait <= 0;
      else if (M_AXI_BVALID && M_AXI_BREADY) begin
        bPending <= 1'b0;
        bWait <= 0;
      end else if (!M_AXI_BVALID) bWait <= bWait + 1;
      if (arHs) begin
        rPending <= 1'b1;
        sArAddr <= M_AXI_ARADDR;
      end
      if (!rPending) rWait <= 0;
      else if (M_AXI_RVALID && M_AXI_RREADY) begin
        rPending <= 1'b0;
        rWait <= 0;
      end else if (!M_AXI_RVALID) rWait <= rWait + 1;
    end
  end

  // Monitors: completion pulse count and VALID-held-until-handshake rule
  int   rspCount = 0;
  int   protoErr = 0;
  logic awPend = 1'b0, wPend = 1'b0, arPend = 1'b0, prevReset = 1'b1;

  always @(posedge clk) begin
    if (rsp_valid) rspCount <= rspCount + 1;
    if (!prevReset && ((awPend && !M_AXI_AWVALID) || (wPend && !M_AXI_WVALID) ||
                       (arPend && !M_AXI_ARVALID)))
      protoErr <= protoErr + 1;
    awPend    <= M_AXI_AWVALID && !M_AXI_AWREADY;
    wPend     <= M_AXI_WVALID && !M_AXI_WREADY;
    arPend    <= M_AXI_ARVALID && !M_AXI_ARREADY;
    prevReset <= reset;
  end

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            awD, wD, arD, bD, rD;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] expData;
    logic [1:0]    expResp;
  } vec_t;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] modelMem [4];
  vec_t          vecs [10];

  function automatic vec_t mkVec(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [SW-1:0] s, input int awD, input int wD,
                                 input int arD, input int bD, input int rD,
                                 input logic [1:0] br, input logic [1:0] rr,
                                 input logic [DW-1:0] ed, input logic [1:0] er);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = d; v.wstrb = s;
    v.awD = awD; v.wD = wD; v.arD = arD; v.bD = bD; v.rD = rD;
    v.bresp = br; v.rresp = rr; v.expData = ed; v.expResp = er;
    return v;
  endfunction

  // Cycles from the accept cycle to the rsp_valid cycle, from protocol timing
  function automatic int expectedLatency(input vec_t v);
    if (v.write) return 3 + ((v.awD > v.wD) ? v.awD : v.wD) + v.bD;
    return 3 + v.arD + v.rD;
  endfunction

  function automatic void modelWrite(input vec_t v);
    for (int b = 0; b < SW; b++)
      if (v.wstrb[b]) modelMem[v.addr[3:2]][8*b +: 8] = v.wdata[8*b +: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents a command and returns at the negedge of the cycle after accept
  task automatic startCommand(input vec_t v, output logic accepted);
    int waitCnt;
    @(negedge clk);
    cfgAwDelay = v.awD; cfgWDelay = v.wD; cfgArDelay = v.arD;
    cfgBDelay = v.bD; cfgRDelay = v.rD; cfgBresp = v.bresp; cfgRresp = v.rresp;
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cmd_valid = 1'b1;
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    accepted = cmd_ready;
    if (accepted) @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(output logic [DW-1:0] data, output logic [1:0] resp,
                              output int lat, output logic gotIt);
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    gotIt = rsp_valid;
    data = rsp_rdata;
    resp = rsp_resp;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag, output logic [DW-1:0] data,
                               output logic [1:0] resp, output int lat, output logic gotIt);
    logic accepted;
    int   startRsp;
    startRsp = rspCount;
    gotIt = 1'b0;
    data = '0;
    resp = '0;
    lat = 0;
    startCommand(v, accepted);
    if (!accepted) begin
      checkOutput({tag, ".acceptTimeout"}, 32'd0, 32'd1);
      return;
    end
    waitResponse(data, resp, lat, gotIt);
    if (!gotIt) begin
      checkOutput({tag, ".rspTimeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    checkOutput({tag, ".pulseWidth"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, ".cmdReadyBack"}, {31'd0, cmd_ready}, 32'd1);
    checkOutput({tag, ".rdataHold"}, rsp_rdata, data);
    checkOutput({tag, ".rspCount"}, rspCount - startRsp, 32'd1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            lat;
    logic          gotIt;
    applyStimulus(v, tag, data, resp, lat, gotIt);
    if (gotIt) begin
      checkOutput({tag, ".rdata"}, data, v.expData);
      checkOutput({tag, ".resp"}, {30'd0, resp}, {30'd0, v.expResp});
      checkOutput({tag, ".latency"}, lat, expectedLatency(v));
    end
    if (v.write) modelWrite(v);
  endtask

  task automatic resetMidTransaction(input vec_t v, input logic onB, input string tag);
    logic accepted;
    int   waitCnt, startRsp;
    startRsp = rspCount;
    startCommand(v, accepted);
    waitCnt = 0;
    while (!(onB ? M_AXI_BREADY : M_AXI_RREADY) && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, ".reachedPhase"}, {31'd0, accepted && (onB ? M_AXI_BREADY : M_AXI_RREADY)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".handshakesIdle"},
                {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    checkOutput({tag, ".rspValid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, ".cmdReady"}, {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) modelMem[k] = '0;
    repeat (4) @(negedge clk);
    checkOutput({tag, ".noRsp"}, rspCount - startRsp, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          v;
    logic          accepted, gotIt;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            lat, startRsp, ai, knobs;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int k = 0; k < 4; k++) modelMem[k] = '0;

    vecs[0] = mkVec(1'b1, 4'h0, 32'h0000_0002, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2'b00);
    vecs[1] = mkVec(1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_0002, 2'b00);
    vecs[2] = mkVec(1'b1, 4'h4, 32'h0000_0001, 4'hF, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2'b00);
    vecs[3] = mkVec(1'b1, 4'hC, 32'hAABB_CCDD, 4'b0101, 0, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2'b00);
    vecs[4] = mkVec(1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 2, 0, 1, 2'b00, 2'b00, 32'h00BB_00DD, 2'b00);
    vecs[5] = mkVec(1'b1, 4'h8, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0, 2'b10);
    vecs[6] = mkVec(1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h1234_5678, 2'b11);
    vecs[7] = mkVec(1'b1, 4'h0, 32'hFFFF_FFFF, 4'b1000, 0, 0, 0, 3, 0, 2'b00, 2'b00, 32'h0, 2'b00);
    vecs[8] = mkVec(1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 4, 2'b00, 2'b00, 32'hFF00_0002, 2'b00);
    vecs[9] = mkVec(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_0001, 2'b00);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.handshakes",
                {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    checkOutput("reset.rspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset.rspRdata", rsp_rdata, 32'd0);
    checkOutput("reset.rspResp", {30'd0, rsp_resp}, 32'd0);
    checkOutput("reset.addrData", {M_AXI_AWADDR, M_AXI_WSTRB, 24'd0} | M_AXI_WDATA, 32'd0);
    checkOutput("reset.prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
    checkOutput("reset.cmdReady", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] late AWREADY with immediate WREADY");
    v = mkVec(1'b1, 4'h4, 32'hCAFE_F00D, 4'b0110, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2'b00);
    startRsp = rspCount;
    startCommand(v, accepted);
    checkOutput("split.accepted", {31'd0, accepted}, 32'd1);
    checkOutput("split.c1Valids", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
    checkOutput("split.c1Addr", {28'd0, M_AXI_AWADDR}, 32'h4);
    checkOutput("split.c1Data", M_AXI_WDATA, 32'hCAFE_F00D);
    checkOutput("split.c1Strb", {28'd0, M_AXI_WSTRB}, 32'h6);
    @(negedge clk);
    checkOutput("split.c2Valids", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("split.c4Awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
    @(negedge clk);
    checkOutput("split.c5AwBready", {30'd0, M_AXI_AWVALID, M_AXI_BREADY}, 32'd1);
    waitResponse(data, resp, lat, gotIt);
    checkOutput("split.gotRsp", {31'd0, gotIt}, 32'd1);
    @(negedge clk);
    checkOutput("split.rspCount", rspCount - startRsp, 32'd1);
    modelWrite(v);
    runVector(mkVec(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h00FE_F001, 2'b00),
              "splitRead");

    $display("[TB] reset during WR_B and RD_R");
    resetMidTransaction(mkVec(1'b1, 4'h8, 32'h5555_AAAA, 4'hF, 0, 0, 0, 8, 0, 2'b00, 2'b00, 32'h0, 2'b00),
                        1'b1, "rstWrB");
    runVector(mkVec(1'b1, 4'hC, 32'h0BAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0, 2'b01), "afterRstW");
    resetMidTransaction(mkVec(1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 8, 2'b00, 2'b00, 32'h0, 2'b00),
                        1'b0, "rstRdR");
    runVector(mkVec(1'b1, 4'h0, 32'h7777_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 2'b00), "afterRstW2");
    runVector(mkVec(1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h7777_0001, 2'b00), "afterRstR");

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      ai = $urandom_range(0, 3);
      knobs = $urandom_range(0, 3);
      v = mkVec($urandom_range(0, 1) == 1, 4'(ai * 4), $urandom(), 4'($urandom_range(1, 15)),
                (knobs == 0) ? 0 : $urandom_range(0, 3), (knobs == 0) ? 0 : $urandom_range(0, 3),
                (knobs == 0) ? 0 : $urandom_range(0, 3), (knobs == 0) ? 0 : $urandom_range(0, 3),
                (knobs == 0) ? 0 : $urandom_range(0, 3),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'h0, 2'b00);
      v.expData = v.write ? 32'h0 : modelMem[v.addr[3:2]];
      v.expResp = v.write ? v.bresp : v.rresp;
      runVector(v, $sformatf("rnd%0d", i));
    end

    checkOutput("protocol.validHeld", protoErr, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
